instqueue: RTL and testbench

- Instruction queue between instruction fetch and the decoder in the out-of-order core.
- Buffers fetched instruction/PC pairs in a circular FIFO and hands them to the decoder one per cycle, only while the dispatcher can accept.
- Flushed on a decoder redirect (JAL) or a ROB misprediction.
- Back-pressures fetch with a full flag.

---
 rtl/instqueue_if.sv | 30 +++
 rtl/instqueue.sv | 91 +++++++++
 tb/tb_instqueue.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instqueue_if.sv
// Fetch-side and decoder-side handshake bundle for the instruction queue.
interface instqueue_if #(
  parameter int IDWidth      = 32,
  parameter int AddressWidth = 32
);
  logic                    if_instqueue_en_in;
  logic [IDWidth-1:0]      if_instqueue_inst_in;
  logic [AddressWidth-1:0] if_instqueue_pc_in;
  logic                    instqueue_if_full_out;
  logic                    dispatcher_instqueue_rdy_in;
  logic                    instqueue_decoder_en_out;
  logic [IDWidth-1:0]      instqueue_decoder_inst_out;
  logic [AddressWidth-1:0] instqueue_decoder_pc_out;
  logic                    decoder_instqueue_rst_in;
  logic                    rob_instqueue_rst_in;

  modport master (
    output if_instqueue_en_in, if_instqueue_inst_in, if_instqueue_pc_in,
    output dispatcher_instqueue_rdy_in, decoder_instqueue_rst_in, rob_instqueue_rst_in,
    input  instqueue_if_full_out, instqueue_decoder_en_out,
    input  instqueue_decoder_inst_out, instqueue_decoder_pc_out
  );

  modport slave (
    input  if_instqueue_en_in, if_instqueue_inst_in, if_instqueue_pc_in,
    input  dispatcher_instqueue_rdy_in, decoder_instqueue_rst_in, rob_instqueue_rst_in,
    output instqueue_if_full_out, instqueue_decoder_en_out,
    output instqueue_decoder_inst_out, instqueue_decoder_pc_out
  );
endinterface

// File: rtl/instqueue.sv
// Circular instruction/PC FIFO between fetch and decode, flushed on redirect.
// Define INSTQUEUE_BYPASS_EN to forward a push straight to the decoder when empty.
module instqueue #(
  parameter int QUEUE_SIZE_LOG = 4,
  parameter int IDWidth        = 32,
  parameter int AddressWidth   = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  instqueue_if.slave  bus
);
  localparam int DEPTH = 1 << QUEUE_SIZE_LOG;
  localparam logic [QUEUE_SIZE_LOG:0] FULL_CNT = {1'b1, {QUEUE_SIZE_LOG{1'b0}}};

  logic [IDWidth-1:0]        inst_mem [DEPTH];
  logic [AddressWidth-1:0]   pc_mem   [DEPTH];
  logic [QUEUE_SIZE_LOG-1:0] head;
  logic [QUEUE_SIZE_LOG-1:0] tail;
  logic [QUEUE_SIZE_LOG:0]   count;
  logic                      en_q;
  logic [IDWidth-1:0]        inst_q;
  logic [AddressWidth-1:0]   pc_q;

  logic flush;
  logic full;
  logic do_pop;
  logic do_push;
  logic bypass;

  always_comb begin
    flush  = bus.decoder_instqueue_rst_in | bus.rob_instqueue_rst_in;
    full   = (count == FULL_CNT);
    do_pop = (count != '0) && bus.dispatcher_instqueue_rdy_in;
`ifdef INSTQUEUE_BYPASS_EN
    bypass = (count == '0) && bus.if_instqueue_en_in && bus.dispatcher_instqueue_rdy_in;
`else
    bypass = 1'b0;
`endif
    // A bypassed instruction never lands in the array.
    do_push = bus.if_instqueue_en_in && !full && !bypass;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      en_q   <= 1'b0;
      inst_q <= '0;
      pc_q   <= '0;
    end else if (!rdy_in) begin
      en_q <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      en_q  <= 1'b0;
    end else begin
      en_q <= do_pop | bypass;
      if (do_pop) begin
        inst_q <= inst_mem[head];
        pc_q   <= pc_mem[head];
        head   <= head + 1'b1;
      end else if (bypass) begin
        inst_q <= bus.if_instqueue_inst_in;
        pc_q   <= bus.if_instqueue_pc_in;
      end
      if (do_push) begin
        tail <= tail + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush && do_push) begin
      inst_mem[tail] <= bus.if_instqueue_inst_in;
      pc_mem[tail]   <= bus.if_instqueue_pc_in;
    end
  end

  assign bus.instqueue_if_full_out      = full;
  assign bus.instqueue_decoder_en_out   = en_q;
  assign bus.instqueue_decoder_inst_out = inst_q;
  assign bus.instqueue_decoder_pc_out   = pc_q;
endmodule

// File: tb/tb_instqueue.sv
// Directed bench for instqueue: ordering, full/wrap, flush, freeze, bypass latency.
module tb_instqueue;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   checks   = 0;
  int   failures = 0;

`ifdef INSTQUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  // Edge (1-based, push on edge 1) after which the first instruction is presented.
  localparam int FIRST = BYP ? 1 : 2;

  instqueue_if bus ();

  instqueue dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle;
    bus.if_instqueue_en_in          = 1'b0;
    bus.if_instqueue_inst_in        = '0;
    bus.if_instqueue_pc_in          = '0;
    bus.decoder_instqueue_rst_in    = 1'b0;
    bus.rob_instqueue_rst_in        = 1'b0;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    bus.if_instqueue_en_in   = 1'b1;
    bus.if_instqueue_inst_in = inst;
    bus.if_instqueue_pc_in   = pc;
  endtask

  task automatic do_reset;
    idle();
    bus.dispatcher_instqueue_rdy_in = 1'b0;
    rdy_in = 1'b1;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    bus.dispatcher_instqueue_rdy_in = 1'b1;
    rdy_in = 1'b1;
    rst_in = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.instqueue_decoder_en_out !== 1'b0) begin
      failures++; $display("FAIL reset_en got=%b exp=0", bus.instqueue_decoder_en_out);
    end
    checks++;
    if (bus.instqueue_decoder_inst_out !== 32'h0) begin
      failures++; $display("FAIL reset_inst got=%h exp=0", bus.instqueue_decoder_inst_out);
    end
    checks++;
    if (bus.instqueue_decoder_pc_out !== 32'h0) begin
      failures++; $display("FAIL reset_pc got=%h exp=0", bus.instqueue_decoder_pc_out);
    end
    checks++;
    if (bus.instqueue_if_full_out !== 1'b0) begin
      failures++; $display("FAIL reset_full got=%b exp=0", bus.instqueue_if_full_out);
    end
    checks++;
    if (dut.count !== 5'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", dut.count);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_basic;
    logic [31:0] pcs [3];
    logic [31:0] insts [3];
    int got = 0;
    int first = -1;
    int last = -1;
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    insts[0] = 32'h00000013; insts[1] = 32'h00100093; insts[2] = 32'h00200113;
    do_reset();
    bus.dispatcher_instqueue_rdy_in = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      if (e <= 3) push(insts[e-1], pcs[e-1]); else idle();
      tick();
      if (bus.instqueue_decoder_en_out === 1'b1) begin
        if (first < 0) first = e;
        last = e;
        checks++;
        if (got >= 3) begin
          failures++; $display("FAIL basic_extra_pop got_pc=%h exp=none", bus.instqueue_decoder_pc_out);
        end else if (bus.instqueue_decoder_pc_out !== pcs[got] ||
                     bus.instqueue_decoder_inst_out !== insts[got]) begin
          failures++;
          $display("FAIL basic_order idx=%0d got=%h/%h exp=%h/%h", got,
                   bus.instqueue_decoder_inst_out, bus.instqueue_decoder_pc_out, insts[got], pcs[got]);
        end
        got++;
      end
    end
    checks++;
    if (got != 3) begin
      failures++; $display("FAIL basic_pop_count got=%0d exp=3", got);
    end
    checks++;
    if (first != FIRST || last != FIRST + 2) begin
      failures++; $display("FAIL basic_latency got_first=%0d got_last=%0d exp_first=%0d", first, last, FIRST);
    end
    checks++;
    if (dut.count !== 5'd0) begin
      failures++; $display("FAIL basic_count got=%0d exp=0", dut.count);
    end
  endtask

  task automatic test_fill;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(32'h1000 + 32'(i), 32'(i * 4));
      tick();
      if (i == 14) begin
        checks++;
        if (bus.instqueue_if_full_out !== 1'b0) begin
          failures++; $display("FAIL fill_full15 got=%b exp=0", bus.instqueue_if_full_out);
        end
      end
    end
    checks++;
    if (bus.instqueue_if_full_out !== 1'b1) begin
      failures++; $display("FAIL fill_full16 got=%b exp=1", bus.instqueue_if_full_out);
    end
    push(32'hdeadbeef, 32'h40);
    tick();
    checks++;
    if (dut.count !== 5'd16 || bus.instqueue_if_full_out !== 1'b1) begin
      failures++; $display("FAIL fill_push17 got_count=%0d exp=16", dut.count);
    end
    idle();
    bus.dispatcher_instqueue_rdy_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (bus.instqueue_decoder_en_out !== 1'b1 || bus.instqueue_decoder_pc_out !== 32'(i * 4) ||
          bus.instqueue_decoder_inst_out !== 32'h1000 + 32'(i)) begin
        failures++;
        $display("FAIL fill_drain idx=%0d got_en=%b pc=%h inst=%h exp_pc=%h", i,
                 bus.instqueue_decoder_en_out, bus.instqueue_decoder_pc_out,
                 bus.instqueue_decoder_inst_out, 32'(i * 4));
      end
      if (i == 0) begin
        checks++;
        if (bus.instqueue_if_full_out !== 1'b0) begin
          failures++; $display("FAIL fill_full_drop got=%b exp=0", bus.instqueue_if_full_out);
        end
      end
    end
    tick();
    checks++;
    if (bus.instqueue_decoder_en_out !== 1'b0 || dut.count !== 5'd0) begin
      failures++;
      $display("FAIL fill_empty got_en=%b count=%0d exp=0/0", bus.instqueue_decoder_en_out, dut.count);
    end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(32'h3000 + 32'(i), 32'h300 + 32'(i * 4));
      tick();
    end
    push(32'h4000, 32'h400);
    bus.dispatcher_instqueue_rdy_in = 1'b1;
    tick();
    checks++;
    if (bus.instqueue_decoder_en_out !== 1'b1 || bus.instqueue_decoder_pc_out !== 32'h300 ||
        dut.count !== 5'd15 || bus.instqueue_if_full_out !== 1'b0) begin
      failures++;
      $display("FAIL fullpp_first got_en=%b pc=%h count=%0d exp=1/300/15",
               bus.instqueue_decoder_en_out, bus.instqueue_decoder_pc_out, dut.count);
    end
    push(32'h4004, 32'h404);
    tick();
    checks++;
    if (bus.instqueue_decoder_pc_out !== 32'h304 || dut.count !== 5'd15 || dut.tail !== 4'd1) begin
      failures++;
      $display("FAIL fullpp_wrap got_pc=%h count=%0d tail=%0d exp=304/15/1",
               bus.instqueue_decoder_pc_out, dut.count, dut.tail);
    end
    idle();
    for (int i = 0; i < 15; i++) begin
      exp_pc = (i < 14) ? 32'h308 + 32'(i * 4) : 32'h404;
      tick();
      checks++;
      if (bus.instqueue_decoder_en_out !== 1'b1 || bus.instqueue_decoder_pc_out !== exp_pc) begin
        failures++;
        $display("FAIL fullpp_drain idx=%0d got_en=%b pc=%h exp_pc=%h", i,
                 bus.instqueue_decoder_en_out, bus.instqueue_decoder_pc_out, exp_pc);
      end
    end
    tick();
    checks++;
    if (bus.instqueue_decoder_en_out !== 1'b0) begin
      failures++; $display("FAIL fullpp_empty got_en=%b exp=0", bus.instqueue_decoder_en_out);
    end
  endtask

  task automatic test_flush;
    int first = -1;
    logic [31:0] first_pc = '0;
    int extra = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(32'h5000 + 32'(i), 32'h500 + 32'(i * 4));
      tick();
    end
    push(32'h6000, 32'h600);
    bus.dispatcher_instqueue_rdy_in = 1'b1;
    bus.decoder_instqueue_rst_in = 1'b1;
    tick();
    checks++;
    if (dut.count !== 5'd0 || bus.instqueue_decoder_en_out !== 1'b0 ||
        bus.instqueue_if_full_out !== 1'b0) begin
      failures++;
      $display("FAIL flush_state got_count=%0d en=%b full=%b exp=0/0/0",
               dut.count, bus.instqueue_decoder_en_out, bus.instqueue_if_full_out);
    end
    checks++;
    if (bus.instqueue_decoder_pc_out !== 32'h0) begin
      failures++; $display("FAIL flush_pc_hold got=%h exp=0", bus.instqueue_decoder_pc_out);
    end
    idle();
    push(32'h1234, 32'h100);
    for (int e = 1; e <= 5; e++) begin
      tick();
      idle();
      if (bus.instqueue_decoder_en_out === 1'b1) begin
        if (first < 0) begin
          first = e;
          first_pc = bus.instqueue_decoder_pc_out;
        end else begin
          extra++;
        end
      end
    end
    checks++;
    if (first != FIRST || first_pc !== 32'h100) begin
      failures++; $display("FAIL flush_next got_edge=%0d pc=%h exp=%0d/100", first, first_pc, FIRST);
    end
    checks++;
    if (extra != 0) begin
      failures++; $display("FAIL flush_stale got=%0d exp=0", extra);
    end
    // ROB-side flush path
    bus.dispatcher_instqueue_rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'h8000 + 32'(i), 32'h800 + 32'(i * 4));
      tick();
    end
    idle();
    bus.rob_instqueue_rst_in = 1'b1;
    tick();
    idle();
    bus.dispatcher_instqueue_rdy_in = 1'b1;
    extra = 0;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (bus.instqueue_decoder_en_out === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || dut.count !== 5'd0) begin
      failures++; $display("FAIL rob_flush got_pops=%0d count=%0d exp=0/0", extra, dut.count);
    end
  endtask

  task automatic test_rdy_freeze;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(32'h7000 + 32'(i), 32'h700 + 32'(i * 4));
      tick();
    end
    rdy_in = 1'b0;
    for (int e = 0; e < 3; e++) begin
      if (e == 1) idle(); else push(32'h9000, 32'h900 + 32'(e));
      bus.dispatcher_instqueue_rdy_in = (e != 1);
      tick();
      checks++;
      if (bus.instqueue_decoder_en_out !== 1'b0 || dut.count !== 5'd4) begin
        failures++;
        $display("FAIL freeze_cycle e=%0d got_en=%b count=%0d exp=0/4", e,
                 bus.instqueue_decoder_en_out, dut.count);
      end
    end
    idle();
    rdy_in = 1'b1;
    bus.dispatcher_instqueue_rdy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.instqueue_decoder_en_out !== 1'b1 || bus.instqueue_decoder_pc_out !== 32'h700 + 32'(i * 4)) begin
        failures++;
        $display("FAIL freeze_drain idx=%0d got_en=%b pc=%h exp_pc=%h", i,
                 bus.instqueue_decoder_en_out, bus.instqueue_decoder_pc_out, 32'h700 + 32'(i * 4));
      end
    end
    tick();
    checks++;
    if (bus.instqueue_decoder_en_out !== 1'b0) begin
      failures++; $display("FAIL freeze_dup got_en=%b exp=0", bus.instqueue_decoder_en_out);
    end
  endtask

  task automatic test_bypass;
    do_reset();
    bus.dispatcher_instqueue_rdy_in = 1'b1;
    push(32'h00000513, 32'h200);
    tick();
    idle();
    checks++;
    if (bus.instqueue_decoder_en_out !== BYP ||
        bus.instqueue_decoder_pc_out !== (BYP ? 32'h200 : 32'h0) ||
        dut.count !== (BYP ? 5'd0 : 5'd1)) begin
      failures++;
      $display("FAIL bypass_edge1 got_en=%b pc=%h count=%0d exp=%b/%h/%0d",
               bus.instqueue_decoder_en_out, bus.instqueue_decoder_pc_out, dut.count,
               BYP, (BYP ? 32'h200 : 32'h0), (BYP ? 0 : 1));
    end
    tick();
    checks++;
    if (bus.instqueue_decoder_en_out !== !BYP || bus.instqueue_decoder_pc_out !== 32'h200 ||
        dut.count !== 5'd0) begin
      failures++;
      $display("FAIL bypass_edge2 got_en=%b pc=%h count=%0d exp=%b/200/0",
               bus.instqueue_decoder_en_out, bus.instqueue_decoder_pc_out, dut.count, !BYP);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    bus.dispatcher_instqueue_rdy_in = 1'b0;
    test_reset();
    test_basic();
    test_fill();
    test_full_push_pop();
    test_flush();
    test_rdy_freeze();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
